// File: rtl/uart_pkg.sv
// Shared types and sizes for the eight-producer UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} uart_arb_state_t;

    localparam int N_PORTS = 8;
    localparam int SEL_W   = 3;

endpackage

// File: rtl/uart_rr_pick_8.sv
// Round-robin pick: first requesting port at or after ptr, wrapping 7 -> 0.
module uart_rr_pick_8
    import uart_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [2*N_PORTS-1:0] req_dbl;
    logic [N_PORTS-1:0]   req_rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        // Doubling the vector turns the rotate into a plain part-select.
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: N_PORTS];
        off     = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k]) off = k[SEL_W-1:0];
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter_8.sv
// Shares one UART transmitter among eight producers: drives the external mux
// select, captures the mux output and hands it over on a valid/ready handshake.
module uart_tx_arbiter_8
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    output logic [SEL_W-1:0]   sel,
    input  logic [WIDTH-1:0]   mux_data,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [N_PORTS-1:0] grant,
    output logic               busy
);

    uart_arb_state_t state, state_next;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    uart_rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sel is committed in IDLE; the external mux has all of LOAD to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            sel      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            grant    <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: if (pick_any) sel <= pick_idx;
                LOAD: begin
                    tx_data  <= mux_data;
                    tx_valid <= 1'b1;
                end
                SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    grant    <= N_PORTS'(1) << sel;
                    ptr      <= sel + SEL_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter_8.sv
// Randomised self-checking bench for uart_tx_arbiter_8 with a round-robin reference model.
module tb_uart_tx_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] mux_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] grant;
    logic       busy;

    logic [7:0] port_data [8];
    int         total = 0;
    int         bad = 0;
    int         m_ptr = 0;

    always #5 clk = ~clk;

    // External 8:1 mux modelled by the bench.
    assign mux_data = port_data[sel];

    uart_tx_arbiter_8 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .sel      (sel),
        .mux_data (mux_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .grant    (grant),
        .busy     (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] onehot(input int p);
        logic [7:0] v;
        v = 8'h00;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < 8; i++) port_data[i] = 8'($urandom);
    endtask

    // Runs until the next grant pulse (or budget), recording what was seen.
    task automatic observe(input int budget, input bit rnd_ready, output int cycles,
                           output logic [7:0] gnt, output logic [7:0] data, output int viol);
        cycles = 0;
        gnt    = 8'h00;
        data   = 8'h00;
        viol   = 0;
        while (cycles < budget) begin
            if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
            if (tx_valid) data = tx_data;
            if ($countones(grant) > 1) viol++;
            if (grant != 8'h00 && tx_valid) viol++;
            if (grant != 8'h00) begin
                gnt = grant;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        tx_ready = 1'b0;
        randomize_data();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        total++;
        if ({sel, tx_data, tx_valid, grant, busy} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state: sel=%0d tx_data=%h tx_valid=%b grant=%b busy=%b required all zero",
                     sel, tx_data, tx_valid, grant, busy);
        end
    endtask

    task automatic test_fairness();
        int cyc, viol, exp;
        logic [7:0] gnt, data;
        randomize_data();
        req = 8'hFF;
        tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp = rr_pick(8'hFF, m_ptr);
            observe(20, 1'b0, cyc, gnt, data, viol);
            total++;
            if (gnt !== onehot(i % 8) || exp != i % 8) begin
                bad++;
                $display("FAIL fair_order[%0d]: grant=%b required %b", i, gnt, onehot(i % 8));
            end
            total++;
            if (cyc != 3 || viol != 0 || data !== port_data[i % 8]) begin
                bad++;
                $display("FAIL fair_timing[%0d]: cycles=%0d viol=%0d data=%h required 3/0/%h",
                         i, cyc, viol, data, port_data[i % 8]);
            end
            m_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, viol;
        logic [7:0] gnt, data;
        port_data[2] = 8'hA5;
        req = 8'b0000_0100;
        tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (sel !== 3'd2 || tx_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_load: sel=%0d tx_valid=%b busy=%b required 2/0/1", sel, tx_valid, busy);
        end
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL single_send: tx_valid=%b tx_data=%h required 1/a5", tx_valid, tx_data);
        end
        observe(10, 1'b0, cyc, gnt, data, viol);
        total++;
        if (gnt !== 8'b0000_0100 || cyc != 1 || viol != 0) begin
            bad++;
            $display("FAIL single_grant: grant=%b cycles=%0d viol=%0d required 00000100/1/0", gnt, cyc, viol);
        end
        req = 8'h00;
        @(negedge clk);
        total++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_after: grant=%b busy=%b required 0/0", grant, busy);
        end
        m_ptr = 3;
    endtask

    task automatic test_backpressure();
        logic [7:0] v_data;
        logic [2:0] v_sel;
        int hold_err;
        randomize_data();
        req = 8'h10;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        v_data = tx_data;
        v_sel = sel;
        total++;
        if (tx_valid !== 1'b1 || v_data !== port_data[4] || v_sel !== 3'd4) begin
            bad++;
            $display("FAIL bp_start: tx_valid=%b data=%h sel=%0d required 1/%h/4",
                     tx_valid, v_data, v_sel, port_data[4]);
        end
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== v_data || sel !== v_sel || grant !== 8'h00) hold_err++;
        end
        total++;
        if (hold_err != 0) begin
            bad++;
            $display("FAIL bp_hold: unstable cycles=%0d required 0", hold_err);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 8'h10 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_grant: grant=%b tx_valid=%b required 00010000/0", grant, tx_valid);
        end
        req = 8'h00;
        @(negedge clk);
        total++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_pulse: grant=%b busy=%b required 0/0", grant, busy);
        end
        m_ptr = 5;
    endtask

    task automatic test_wrap();
        int cyc, viol, exp;
        logic [7:0] gnt, data;
        logic [7:0] pats [3];
        pats[0] = 8'b0010_0000;
        pats[1] = 8'b0100_0001;
        pats[2] = 8'b0000_0001;
        randomize_data();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = pats[i];
            exp = rr_pick(pats[i], m_ptr);
            observe(20, 1'b0, cyc, gnt, data, viol);
            total++;
            if (gnt !== onehot(exp) || data !== port_data[exp] || viol != 0) begin
                bad++;
                $display("FAIL wrap[%0d]: grant=%b data=%h required %b/%h",
                         i, gnt, data, onehot(exp), port_data[exp]);
            end
            m_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        randomize_data();
        req = 8'h08;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        req = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== port_data[3] || busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_hold: tx_valid=%b data=%h busy=%b required 1/%h/1",
                     tx_valid, tx_data, busy, port_data[3]);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 8'h08) begin
            bad++;
            $display("FAIL wd_grant: grant=%b required 00001000", grant);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant !== 8'h00) begin
            bad++;
            $display("FAIL wd_idle: busy=%b grant=%b required 0/0", busy, grant);
        end
        m_ptr = 4;
    endtask

    task automatic test_reset_mid_send();
        int cyc, viol;
        logic [7:0] gnt, data;
        randomize_data();
        req = 8'h04;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b0 || grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_send: tx_valid=%b grant=%b sel=%0d busy=%b required 0/0/0/0",
                     tx_valid, grant, sel, busy);
        end
        req = 8'h80;
        tx_ready = 1'b1;
        rst = 1'b0;
        m_ptr = 0;
        observe(20, 1'b0, cyc, gnt, data, viol);
        total++;
        if (gnt !== 8'h80 || data !== port_data[7] || cyc != 3) begin
            bad++;
            $display("FAIL rst_then_p7: grant=%b data=%h cycles=%0d required 10000000/%h/3",
                     gnt, data, cyc, port_data[7]);
        end
        m_ptr = 0;
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset_ptr();
        int cyc, viol;
        logic [7:0] gnt, data;
        randomize_data();
        req = 8'h04;
        tx_ready = 1'b1;
        observe(20, 1'b0, cyc, gnt, data, viol);
        req = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        req = 8'h82;
        observe(20, 1'b0, cyc, gnt, data, viol);
        total++;
        if (gnt !== onehot(rr_pick(8'h82, m_ptr))) begin
            bad++;
            $display("FAIL rst_ptr: grant=%b required %b", gnt, onehot(rr_pick(8'h82, m_ptr)));
        end
        m_ptr = 2;
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, viol, exp, errs;
        logic [7:0] gnt, data, r;
        errs = 0;
        for (int n = 0; n < 40; n++) begin
            randomize_data();
            r = 8'($urandom);
            if (r == 8'h00) r = 8'h01;
            req = r;
            exp = rr_pick(r, m_ptr);
            observe(300, 1'b1, cyc, gnt, data, viol);
            total++;
            if (gnt !== onehot(exp) || data !== port_data[exp] || viol != 0 || cyc < 3) begin
                bad++;
                errs++;
                if (errs < 6)
                    $display("FAIL random[%0d]: req=%b grant=%b data=%h cycles=%0d viol=%0d required %b/%h",
                             n, r, gnt, data, cyc, viol, onehot(exp), port_data[exp]);
            end
            m_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) port_data[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_wrap();
        test_withdraw();
        test_reset_mid_send();
        test_reset_ptr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
